// File: rtl/imem_loader.sv
// Y86-64 instruction memory with a byte-serial valid/ready program loader and a
// combinational 10-byte fetch window. Define IMEM_CHECKSUM_EN to add an XOR checksum output.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [63:0]       load_base,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              in_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   byte_count,
  input  logic [63:0]       fetch_pc,
  output logic [79:0]       fetch_bytes,
  output logic              imem_error
`ifdef IMEM_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        mem_q [MEM_BYTES];

  logic start_s;
  logic base_ok_s;
  logic xfer_s;
  logic at_end_s;

  assign start_s   = load_start && ((state_q == S_IDLE) || (state_q == S_ERROR));
  assign base_ok_s = (load_base < 64'(MEM_BYTES));
  assign xfer_s    = (state_q == S_LOAD) && in_valid;
  assign at_end_s  = (ptr_q == ADDR_W'(MEM_BYTES - 1));

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign checksum = csum_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_s) begin
          state_d = base_ok_s ? S_LOAD : S_ERROR;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        // A final byte wins over overflow, even when it lands on the last address.
        if (xfer_s && in_last) begin
          state_d = S_DONE;
        end else if (xfer_s && at_end_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
`ifdef IMEM_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (start_s) begin
      cnt_d = '0;
`ifdef IMEM_CHECKSUM_EN
      csum_d = 8'h00;
`endif
      if (base_ok_s) begin
        ptr_d = load_base[ADDR_W-1:0];
      end else begin
        ptr_d = ptr_q;
      end
    end else if (xfer_s) begin
      ptr_d = ptr_q + ADDR_W'(1);
      cnt_d = cnt_q + CW'(1);
`ifdef IMEM_CHECKSUM_EN
      csum_d = csum_q ^ in_byte;
`endif
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer_s) begin
      mem_q[ptr_q] <= in_byte;
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_ready  = 1'b1;
        load_busy = 1'b1;
      end
      S_DONE:  load_done  = 1'b1;
      S_ERROR: load_error = 1'b1;
      default: in_ready   = 1'b0;
    endcase
  end

  assign byte_count = cnt_q;
  assign imem_error = (fetch_pc >= 64'(MEM_BYTES));

  // 65-bit sums so a PC near 2^64 cannot wrap back into the valid range.
  for (genvar g = 0; g < 10; g++) begin : g_fetch
    logic [64:0] addr_s;
    assign addr_s = {1'b0, fetch_pc} + 65'(g);
    assign fetch_bytes[8*g +: 8] = (addr_s < 65'(MEM_BYTES)) ? mem_q[addr_s[ADDR_W-1:0]] : 8'h00;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: accepted bytes are queued as they are driven
// and read back through the fetch window after each load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [63:0] load_base;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready, load_busy, load_done, load_error;
  logic [10:0] byte_count;
  logic [63:0] fetch_pc;
  logic [79:0] fetch_bytes;
  logic        imem_error;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
    .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .load_busy(load_busy), .load_done(load_done), .load_error(load_error),
    .byte_count(byte_count), .fetch_pc(fetch_pc), .fetch_bytes(fetch_bytes),
    .imem_error(imem_error)
`ifdef IMEM_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  data;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int vectors_s     = 0;
  int miscompares_s = 0;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors_s++;
    if (got !== exp) begin
      miscompares_s++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [63:0] base);
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
  endtask

  // Drive one valid byte; the bench decides whether the loader should take it.
  task automatic send(input logic [63:0] addr, input logic [7:0] b, input logic last, input logic accept);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    check_val("in_ready", {79'd0, in_ready}, {79'd0, accept});
    if (accept) sb_q.push_back('{addr: addr, data: b});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      sb_entry_t e;
      e = sb_q.pop_front();
      fetch_pc = e.addr;
      #1;
      check_val("mem_rd", {72'd0, fetch_bytes[7:0]}, {72'd0, e.data});
    end
  endtask

  logic [7:0] prog [12] = '{8'h30, 8'hF2, 8'h08, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
  logic [4:0] bp_valid = 5'b11001;  // bit i = in_valid in gap cycle i
  logic [7:0] bp_data [5] = '{8'h11, 8'hEE, 8'hEE, 8'h44, 8'h55};

  initial begin
    int bp_addr;
    rst_n = 1'b0; load_start = 1'b0; load_base = 64'd0;
    in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; fetch_pc = 64'd0;
    #12;
    check_val("rst_ready", {79'd0, in_ready}, 80'd0);
    check_val("rst_busy",  {79'd0, load_busy}, 80'd0);
    check_val("rst_done",  {79'd0, load_done}, 80'd0);
    check_val("rst_err",   {79'd0, load_error}, 80'd0);
    check_val("rst_cnt",   {69'd0, byte_count}, 80'd0);
    rst_n = 1'b1;
    tick();

    // Basic load at address 0
    start_load(64'd0);
    check_val("busy", {79'd0, load_busy}, 80'd1);
    for (int i = 0; i < 12; i++) send(64'(i), prog[i], (i == 11), 1'b1);
    check_val("done_pulse", {79'd0, load_done}, 80'd1);
    check_val("cnt12", {69'd0, byte_count}, 80'd12);
    check_val("done_ready", {79'd0, in_ready}, 80'd0);
    tick();
    check_val("done_once", {79'd0, load_done}, 80'd0);
    check_val("cnt12_hold", {69'd0, byte_count}, 80'd12);
    drain();
    fetch_pc = 64'd0; #1;
    check_val("win0", {56'd0, fetch_bytes[23:0]}, {56'd0, 24'h08F230});
    fetch_pc = 64'd10; #1;
    check_val("win10", {64'd0, fetch_bytes[15:0]}, {64'd0, 16'h0010});
    tick();

    // Backpressure gaps at base 100
    start_load(64'd100);
    bp_addr = 100;
    for (int i = 0; i < 5; i++) begin
      if (bp_valid[i]) begin
        send(64'(bp_addr), bp_data[i], (i == 4), 1'b1);
        bp_addr++;
      end else begin
        in_valid = 1'b0;
        in_byte  = bp_data[i];
        tick();
      end
    end
    check_val("bp_done", {79'd0, load_done}, 80'd1);
    check_val("bp_cnt", {69'd0, byte_count}, 80'd3);
    drain();
    tick();

    // Range errors on the fetch side
    fetch_pc = 64'd1024; #1;
    check_val("ierr1024", {79'd0, imem_error}, 80'd1);
    check_val("bytes1024", fetch_bytes, 80'd0);
    fetch_pc = 64'd1020; #1;
    check_val("ierr1020", {79'd0, imem_error}, 80'd0);
    check_val("hi1020", {32'd0, fetch_bytes[79:32]}, 80'd0);
    fetch_pc = 64'hFFFF_FFFF_FFFF_FFFF; #1;
    check_val("ierr_max", {79'd0, imem_error}, 80'd1);
    check_val("bytes_max", fetch_bytes, 80'd0);

    // Out-of-range load base
    start_load(64'd2000);
    check_val("base_err", {79'd0, load_error}, 80'd1);
    check_val("base_cnt", {69'd0, byte_count}, 80'd0);
    send(64'd0, 8'h99, 1'b0, 1'b0);
    check_val("base_err_hold", {79'd0, load_error}, 80'd1);

    // Overflow at the top of memory, restarted from ERROR
    start_load(64'd1022);
    check_val("ovf_errclr", {79'd0, load_error}, 80'd0);
    send(64'd1022, 8'hAA, 1'b0, 1'b1);
    send(64'd1023, 8'hBB, 1'b0, 1'b1);
    check_val("ovf_err", {79'd0, load_error}, 80'd1);
    check_val("ovf_cnt", {69'd0, byte_count}, 80'd2);
    send(64'd0, 8'hCC, 1'b0, 1'b0);
    check_val("ovf_cnt_hold", {69'd0, byte_count}, 80'd2);
    drain();

    // Reset in the middle of a load
    start_load(64'd200);
    send(64'd200, 8'h5A, 1'b0, 1'b1);
    send(64'd201, 8'hA5, 1'b0, 1'b1);
    in_valid = 1'b1; in_byte = 8'hC3;
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_ready", {79'd0, in_ready}, 80'd0);
    check_val("mr_busy", {79'd0, load_busy}, 80'd0);
    check_val("mr_cnt", {69'd0, byte_count}, 80'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("mr_nodone", {79'd0, load_done}, 80'd0);
    end
    drain();

`ifdef IMEM_CHECKSUM_EN
    start_load(64'd300);
    send(64'd300, 8'h01, 1'b0, 1'b1);
    send(64'd301, 8'h02, 1'b0, 1'b1);
    send(64'd302, 8'h04, 1'b1, 1'b1);
    check_val("cs_done", {79'd0, load_done}, 80'd1);
    check_val("cs_val", {72'd0, checksum}, 80'h07);
    tick();
    check_val("cs_hold", {72'd0, checksum}, 80'h07);
    start_load(64'd400);
    check_val("cs_clr", {72'd0, checksum}, 80'd0);
    send(64'd400, 8'h00, 1'b1, 1'b1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_s, miscompares_s);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory for the Y86-64 SEQ processor, plus a byte-serial program loader.
- The loader side writes program bytes into a byte-addressed array through a valid/ready stream. This is the write end of the memory that fetch reads.
- The fetch side gives a combinational 10-byte window at fetch_pc, which covers the longest Y86 instruction. It also raises imem_error for out-of-range PCs.
- Sits beside fetch; the load is driven by the bench or the boot logic before the CPU runs.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, address width; must equal clog2(MEM_BYTES).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_start  input  1  one-cycle request to begin a load; sampled in IDLE and ERROR only.
- load_base  input  64  start byte address, sampled together with load_start.
- in_valid  input  1  stream byte valid.
- in_byte  input  8  stream data byte.
- in_last  input  1  marks the final byte of the program.
- in_ready  output  1  loader can accept a byte; high only in LOAD.
- load_busy  output  1  high in LOAD.
- load_done  output  1  one-cycle pulse after the last byte is written.
- load_error  output  1  sticky error flag; high in ERROR.
- byte_count  output  ADDR_W+1  number of bytes written in the current or most recent load.
- fetch_pc  input  64  fetch address.
- fetch_bytes  output  80  bits [8i+7:8i] = mem[fetch_pc+i], for i=0..9.
- imem_error  output  1  fetch_pc >= MEM_BYTES.

Behaviour:
- State machine states: IDLE, LOAD, DONE, ERROR.
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; the write pointer goes to 0; byte_count goes to 0.
  - in_ready, load_busy, load_done and load_error all go to 0.
  - Memory contents are not cleared.
- IDLE or ERROR with load_start=1:
  - If load_base < MEM_BYTES: go to LOAD; pointer <= load_base[ADDR_W-1:0]; byte_count <= 0; load_error clears.
  - If load_base >= MEM_BYTES: go to, or stay in, ERROR; byte_count <= 0.
- LOAD:
  - in_ready=1. A byte is transferred when in_valid & in_ready.
  - Each transfer: mem[pointer] <= in_byte; pointer increments; byte_count increments.
  - Transfer with in_last=1: go to DONE, including when that byte lands at MEM_BYTES-1.
  - Transfer at pointer = MEM_BYTES-1 with in_last=0: the byte is written, then go to ERROR (overflow). There is no wrap-around.
  - load_start in LOAD is ignored.
- DONE: load_done=1 for exactly one cycle, in_ready=0, then IDLE.
- ERROR: load_error=1; in_ready=0; stays in ERROR until load_start or reset.
- Fetch read path is purely combinational, with zero latency.
  - A byte at address >= MEM_BYTES reads as 8'h00.
  - imem_error = (fetch_pc >= MEM_BYTES), compared on all 64 bits.
  - Same-cycle write and read of the same address: fetch_bytes shows the old value until after the clock edge.
- Reset mid-load: state returns to IDLE immediately; bytes already written are kept; no load_done pulse.
- byte_count holds its value after DONE or ERROR until the next accepted load_start.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (8 bits), cleared to 0 on reset and on every accepted load_start.
  - Each transfer: checksum <= checksum ^ in_byte.
  - The value is stable from the load_done pulse until the next load_start.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic load and fetch:
  - Stimulus: load_base=0; stream 30 F2 08 00 00 00 00 00 00 00 10 00 with in_last on the final byte.
  - Required: load_done pulses one cycle after the last transfer; byte_count=12.
  - Required: fetch_pc=0 gives fetch_bytes[7:0]=8'h30, [15:8]=8'hF2, [23:16]=8'h08; fetch_pc=10 gives fetch_bytes[7:0]=8'h10, [15:8]=8'h00.
- Backpressure gaps:
  - Stimulus: in_valid toggled 1,0,0,1,1 with load_base=100.
  - Required: only the 3 valid bytes are written, at 100, 101 and 102; byte_count=3.
- Range errors:
  - fetch_pc=1024 -> imem_error=1 and fetch_bytes=0.
  - fetch_pc=1020 -> imem_error=0 and bytes 4..9 read 0.
  - load_start with load_base=2000 -> load_error=1 and in_ready stays 0.
- Overflow:
  - Stimulus: load_base=1022; send 3 bytes AA BB CC with in_last=0 throughout.
  - Required: mem[1022]=AA and mem[1023]=BB; ERROR entered after the BB transfer; CC is not accepted (in_ready=0); byte_count=2.
- Reset mid-load:
  - Stimulus: drop rst_n low after 2 of 5 bytes.
  - Required: state is IDLE, in_ready=0 and byte_count=0 immediately; the 2 written bytes are readable; no load_done pulse.
- Checksum (IMEM_CHECKSUM_EN defined):
  - Stimulus: load 01 02 04.
  - Required: checksum=8'h07 at load_done; a new load_start clears it to 0.
